// File: rtl/pipeline_join_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_join_buf_pkg
// Brief   : Shared defaults and width helpers for the buffered N-to-1 join.
// Revision: 1.0 - initial release
// ============================================================================
package pipeline_join_buf_pkg;

    localparam int unsigned DEF_N     = 2;
    localparam int unsigned DEF_W     = 32;
    localparam int unsigned DEF_DEPTH = 2;

    // Occupancy must represent 0..DEPTH inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_join_buf_if.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_join_buf_if
// Brief   : N producer channels in, one joined valid/ready channel out.
// Revision: 1.0 - initial release
// ============================================================================
interface pipeline_join_buf_if
    import pipeline_join_buf_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned W = DEF_W
);
    logic [N-1:0]          i_valid;
    logic [N-1:0]          i_ready;
    logic [N-1:0][W-1:0]   i_data;
    logic                  o_valid;
    logic                  o_ready;
    logic [N*W-1:0]        o_data;

    modport slave  (input  i_valid, i_data, o_ready,
                    output i_ready, o_valid, o_data);
    modport master (output i_valid, i_data, o_ready,
                    input  i_ready, o_valid, o_data);
endinterface
`default_nettype wire

// File: rtl/pipeline_join_buf_fifo.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_fifo
// Brief   : Per-channel circular FIFO; full/empty derived from registered count.
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_fifo
    import pipeline_join_buf_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         i_push,
    input  wire logic [W-1:0] i_data,
    input  wire logic         i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [W-1:0]      o_data
);
    localparam int unsigned   CW     = cnt_width(DEPTH);
    localparam int unsigned   PW     = ptr_width(DEPTH);
    localparam logic [PW-1:0] C_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == C_FULL);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    // Push is refused while full even if a pop happens on the same edge.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop  & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_join_buf.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_join_buf
// Brief   : Buffered N-to-1 join; one beat pops one word from every channel.
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_join_buf
    import pipeline_join_buf_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned W     = DEF_W,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input wire logic              clk,
    input wire logic              rst_n,
    pipeline_join_buf_if.slave    bus
);
    logic [N-1:0]        w_ready;
    logic [N-1:0]        w_avail;
    logic [N-1:0][W-1:0] w_head;
    logic                w_pop;

    assign bus.i_ready = w_ready;
    assign bus.o_valid = &w_avail;
    assign w_pop       = (&w_avail) & bus.o_ready;

    generate
        for (genvar gi = 0; gi < int'(N); gi++) begin : g_ch
            logic w_full;
            logic w_empty;

            pipeline_fifo #(
                .W     (W),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_push  (bus.i_valid[gi]),
                .i_data  (bus.i_data[gi]),
                .i_pop   (w_pop),
                .o_full  (w_full),
                .o_empty (w_empty),
                .o_data  (w_head[gi])
            );

            assign w_ready[gi]             = ~w_full;
            assign w_avail[gi]             = ~w_empty;
            assign bus.o_data[gi*W +: W]   = w_head[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipeline_join_buf.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_join_buf
// Brief   : Directed self-checking bench for the buffered N-to-1 join.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_join_buf;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pipeline_join_buf_if #(.N(2), .W(8)) a_if ();
    pipeline_join_buf_if #(.N(3), .W(8)) b_if ();
    pipeline_join_buf_if #(.N(2), .W(8)) c_if ();

    pipeline_join_buf #(.N(2), .W(8), .DEPTH(2)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    pipeline_join_buf #(.N(3), .W(8), .DEPTH(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
    pipeline_join_buf #(.N(2), .W(8), .DEPTH(1)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] n0, n1;
    logic       v0, v1, rdy0, rdy1;
    int         beats;

    initial begin
        rst_n = 1'b1;
        a_if.i_valid = '0; a_if.i_data = '0; a_if.o_ready = 1'b0;
        b_if.i_valid = '0; b_if.i_data = '0; b_if.o_ready = 1'b0;
        c_if.i_valid = '0; c_if.i_data = '0; c_if.o_ready = 1'b0;
        #1 rst_n = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("rst_a_ovalid", 32'(a_if.o_valid), 32'd0);
        chk("rst_a_iready", 32'(a_if.i_ready), 32'h3);
        chk("rst_b_iready", 32'(b_if.i_ready), 32'h7);
        chk("rst_c_ovalid", 32'(c_if.o_valid), 32'd0);
        rst_n = 1'b1;

        // Skewed arrival: ch0 at cycle 0, ch1 at cycle 3
        a_if.i_valid = 2'b01; a_if.i_data[0] = 8'h11;
        cyc();
        a_if.i_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            chk("skew_wait", 32'(a_if.o_valid), 32'd0);
            if (i == 2) begin
                a_if.i_valid = 2'b10; a_if.i_data[1] = 8'hA5;
            end
            cyc();
        end
        a_if.i_valid = 2'b00;
        chk("skew_ovalid", 32'(a_if.o_valid), 32'd1);
        chk("skew_odata", 32'(a_if.o_data), 32'hA511);
        cyc();
        chk("skew_hold_v", 32'(a_if.o_valid), 32'd1);
        chk("skew_hold_d", 32'(a_if.o_data), 32'hA511);
        a_if.o_ready = 1'b1;
        cyc();
        a_if.o_ready = 1'b0;
        chk("skew_drained", 32'(a_if.o_valid), 32'd0);
        chk("skew_iready", 32'(a_if.i_ready), 32'h3);

        // Backpressure fill on ch0
        a_if.i_valid = 2'b01; a_if.i_data[0] = 8'h01;
        chk("bp_rdy_empty", 32'(a_if.i_ready[0]), 32'd1);
        cyc();
        a_if.i_data[0] = 8'h02;
        cyc();
        a_if.i_data[0] = 8'h03;
        chk("bp_full0", 32'(a_if.i_ready[0]), 32'd0);
        a_if.i_valid = 2'b11; a_if.i_data[1] = 8'h10;
        cyc();
        chk("bp_full0_hold", 32'(a_if.i_ready[0]), 32'd0);
        a_if.i_data[1] = 8'h20;
        cyc();
        a_if.i_valid = 2'b01;
        chk("bp_ovalid", 32'(a_if.o_valid), 32'd1);
        chk("bp_beat1", 32'(a_if.o_data), 32'h1001);
        chk("bp_both_full", 32'(a_if.i_ready), 32'h0);
        a_if.o_ready = 1'b1;
        cyc();
        chk("bp_beat2", 32'(a_if.o_data), 32'h2002);
        chk("bp_rdy_after_pop", 32'(a_if.i_ready), 32'h3);
        cyc();
        a_if.i_valid = 2'b00;
        chk("bp_ch1_empty", 32'(a_if.o_valid), 32'd0);
        chk("bp_rdy_one", 32'(a_if.i_ready), 32'h3);
        a_if.i_valid = 2'b10; a_if.i_data[1] = 8'h30;
        cyc();
        a_if.i_valid = 2'b00;
        chk("bp_beat3", 32'(a_if.o_data), 32'h3003);
        chk("bp_beat3_v", 32'(a_if.o_valid), 32'd1);
        cyc();
        a_if.o_ready = 1'b0;
        chk("bp_done", 32'(a_if.o_valid), 32'd0);

        // Asynchronous reset with two words buffered in ch0
        a_if.i_valid = 2'b01; a_if.i_data[0] = 8'h55;
        cyc();
        a_if.i_data[0] = 8'h66;
        cyc();
        a_if.i_valid = 2'b00;
        chk("mr_full", 32'(a_if.i_ready), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_async_rdy", 32'(a_if.i_ready), 32'h3);
        chk("mr_async_v", 32'(a_if.o_valid), 32'd0);
        cyc();
        chk("mr_cycle_v", 32'(a_if.o_valid), 32'd0);
        rst_n = 1'b1;
        a_if.i_valid = 2'b11; a_if.i_data[0] = 8'h88; a_if.i_data[1] = 8'h77;
        cyc();
        a_if.i_valid = 2'b00;
        chk("mr_fresh", 32'(a_if.o_data), 32'h7788);
        a_if.o_ready = 1'b1;
        cyc();
        chk("mr_empty", 32'(a_if.o_valid), 32'd0);

        // Streaming on the 3-channel instance
        b_if.o_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            b_if.i_valid = 3'b111;
            b_if.i_data  = {8'(k), 8'(k), 8'(k)};
            cyc();
            chk("str_v", 32'(b_if.o_valid), 32'd1);
            chk("str_d", 32'(b_if.o_data), 32'({3{8'(k)}}));
            chk("str_rdy", 32'(b_if.i_ready), 32'h7);
        end
        b_if.i_valid = 3'b000;
        cyc();
        chk("str_end", 32'(b_if.o_valid), 32'd0);

        // Random-gap push/pop against a queue scoreboard
        a_if.o_ready = 1'b1;
        n0 = 8'h00; n1 = 8'h80; beats = 0;
        for (int c = 0; c < 400 && beats < 16; c++) begin
            rdy0 = (q0.size() < 2);
            rdy1 = (q1.size() < 2);
            chk("rnd_v", 32'(a_if.o_valid), 32'(q0.size() > 0 && q1.size() > 0));
            chk("rnd_rdy", 32'(a_if.i_ready), 32'({rdy1, rdy0}));
            if (q0.size() > 0 && q1.size() > 0) begin
                chk("rnd_d", 32'(a_if.o_data), 32'({q1[0], q0[0]}));
                void'(q0.pop_front());
                void'(q1.pop_front());
                beats++;
            end
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            a_if.i_valid = {v1, v0};
            a_if.i_data[0] = n0;
            a_if.i_data[1] = n1;
            if (v0 && rdy0) begin q0.push_back(n0); n0 = n0 + 8'd1; end
            if (v1 && rdy1) begin q1.push_back(n1); n1 = n1 + 8'd1; end
            cyc();
        end
        a_if.i_valid = 2'b00;
        chk("rnd_beats", 32'(beats), 32'd16);

        // DEPTH=1: one beat every two cycles
        c_if.o_ready = 1'b1;
        c_if.i_valid = 2'b11;
        for (int k = 0; k < 10; k++) begin
            c_if.i_data[0] = 8'(k);
            c_if.i_data[1] = 8'(k + 8'h40);
            cyc();
            chk("d1_v", 32'(c_if.o_valid), 32'd1);
            chk("d1_rdy_full", 32'(c_if.i_ready), 32'h0);
            chk("d1_d", 32'(c_if.o_data), 32'({8'(k + 8'h40), 8'(k)}));
            c_if.i_data[0] = 8'hEE;
            c_if.i_data[1] = 8'hEE;
            cyc();
            chk("d1_gap_v", 32'(c_if.o_valid), 32'd0);
            chk("d1_gap_rdy", 32'(c_if.i_ready), 32'h3);
        end
        c_if.i_valid = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
